// File: rtl/umul_prod_accum.sv
// Packet accumulator downstream of the 8-bit unsigned multiplier: sums a stream of
// 16-bit products per in_last-delimited packet and presents sum, beat count and overflow.
module umul_prod_accum #(
    parameter int SUM_NBITS = 24,
    parameter int CNT_NBITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_val,
    output logic                 in_rdy,
    input  logic [15:0]          in_prod,
    input  logic                 in_last,
    output logic                 out_val,
    input  logic                 out_rdy,
    output logic [SUM_NBITS-1:0] out_sum,
    output logic [CNT_NBITS-1:0] out_count,
    output logic                 out_ovf
);

    localparam logic [CNT_NBITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_NBITS-1:0] CNT_ONE = CNT_NBITS'(1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [SUM_NBITS-1:0]   acc;
    logic [CNT_NBITS-1:0]   count;
    logic                   ovf;
    logic                   accept;
    logic                   take;
    logic [SUM_NBITS:0]     sum_ext;

    // One extra bit on the adder captures the carry-out that feeds the sticky flag.
    assign sum_ext = {1'b0, acc} + (SUM_NBITS + 1)'(in_prod);

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        next_state = state;
        in_rdy     = 1'b0;
        out_val    = 1'b0;
        case (state)
            ACCUM: begin
                in_rdy = 1'b1;
                if (in_val && in_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    next_state = ACCUM;
                end
            end
            default: next_state = ACCUM;
        endcase
    end

    assign accept = in_val & in_rdy;
    assign take   = out_val & out_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (take) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= sum_ext[SUM_NBITS-1:0];
            ovf   <= ovf | sum_ext[SUM_NBITS];
            count <= (count == CNT_MAX) ? count : count + CNT_ONE;
        end
    end

    // Running registers are visible in ACCUM too; the consumer qualifies with out_val.
    assign out_sum   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_umul_prod_accum.sv
// Self-checking bench for umul_prod_accum: packet table plus directed corner sequences,
// with a scoreboard queue of expected results compared whenever a result is taken.
module tb_umul_prod_accum;

    localparam int SUM_NBITS = 24;
    localparam int CNT_NBITS = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_val;
    logic                 in_rdy;
    logic [15:0]          in_prod;
    logic                 in_last;
    logic                 out_val;
    logic                 out_rdy;
    logic [SUM_NBITS-1:0] out_sum;
    logic [CNT_NBITS-1:0] out_count;
    logic                 out_ovf;

    umul_prod_accum #(
        .SUM_NBITS(SUM_NBITS),
        .CNT_NBITS(CNT_NBITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_prod  (in_prod),
        .in_last  (in_last),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SUM_NBITS-1:0] sum;
        logic [CNT_NBITS-1:0] cnt;
        logic                 ovf;
    } res_t;

    typedef struct {
        int unsigned          n;
        logic [3:0][15:0]     beats;
        logic [SUM_NBITS-1:0] sum;
        logic [CNT_NBITS-1:0] cnt;
        logic                 ovf;
    } vec_t;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Sole driver of out_rdy; updates after the driver's posedge+1 stimulus settles.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_rdy = 1'b0;
            1:       out_rdy = 1'b1;
            default: out_rdy = 1'($urandom_range(0, 1));
        endcase
    end

    // Result monitor: a transfer happens at the next posedge when both are high.
    always @(negedge clk) begin
        res_t e;
        if (!reset && out_val && out_rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result actual_sum=%0d required=none", out_sum);
            end else begin
                e = sb.pop_front();
                check("res_sum", 64'(out_sum), 64'(e.sum));
                check("res_count", 64'(out_count), 64'(e.cnt));
                check("res_ovf", 64'(out_ovf), 64'(e.ovf));
            end
        end
    end

    task automatic send_beat(input logic [15:0] p, input logic l);
        bit done = 0;
        in_val  = 1'b1;
        in_prod = p;
        in_last = l;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = in_rdy;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL beat_timeout actual=not_accepted required=accepted");
        end
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_val  = 1'b0;
            in_prod = 16'($urandom);
            in_last = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_last = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic push_exp(input logic [SUM_NBITS-1:0] s, input logic [CNT_NBITS-1:0] c,
                            input logic o);
        res_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        sb.push_back(e);
    endtask

    vec_t vecs[5];

    initial begin
        longint unsigned model_sum;
        int              model_cnt;
        int              n;
        logic [15:0]     p;

        vecs[0] = '{3, {16'd0, 16'd156, 16'd72, 16'd6}, 24'd234, 8'd3, 1'b0};
        vecs[1] = '{1, {16'd0, 16'd0, 16'd0, 16'd65025}, 24'd65025, 8'd1, 1'b0};
        vecs[2] = '{2, {16'd0, 16'd0, 16'd0, 16'd0}, 24'd0, 8'd2, 1'b0};
        vecs[3] = '{4, {16'd65535, 16'd65535, 16'd65535, 16'd65535}, 24'd262140, 8'd4, 1'b0};
        vecs[4] = '{2, {16'd0, 16'd0, 16'd255, 16'd1}, 24'd256, 8'd2, 1'b0};

        reset   = 1'b1;
        in_val  = 1'b0;
        in_prod = '0;
        in_last = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        check("rst_in_rdy", 64'(in_rdy), 64'd1);
        check("rst_out_val", 64'(out_val), 64'd0);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table packets with result latency and bubble checks.
        for (int v = 0; v < 5; v++) begin
            push_exp(vecs[v].sum, vecs[v].cnt, vecs[v].ovf);
            for (int b = 0; b < int'(vecs[v].n); b++) begin
                send_beat(vecs[v].beats[b], b == int'(vecs[v].n) - 1);
            end
            @(negedge clk);
            check("lat_out_val", 64'(out_val), 64'd1);
            check("lat_in_rdy_low", 64'(in_rdy), 64'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("bubble_in_rdy_back", 64'(in_rdy), 64'd1);
            check("bubble_out_val_low", 64'(out_val), 64'd0);
            @(posedge clk);
            #1;
        end

        // Backpressure: result held stable for five cycles.
        rdy_mode = 0;
        push_exp(24'd18500, 8'd2, 1'b0);
        send_beat(16'd1600, 1'b0);
        send_beat(16'd16900, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_val", 64'(out_val), 64'd1);
            check("bp_in_rdy", 64'(in_rdy), 64'd0);
            check("bp_out_sum", 64'(out_sum), 64'd18500);
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_taken_out_val", 64'(out_val), 64'd0);
        check("bp_taken_in_rdy", 64'(in_rdy), 64'd1);
        @(posedge clk);
        #1;

        // Overflow wrap and count saturation, then a clean follow-up packet.
        push_exp(24'd64259, 8'd255, 1'b1);
        for (int b = 0; b < 259; b++) begin
            send_beat(16'd65025, b == 258);
        end
        push_exp(24'd4, 8'd1, 1'b0);
        send_beat(16'd4, 1'b1);
        drain();

        // Reset mid-packet discards the partial sum.
        send_beat(16'd1000, 1'b0);
        send_beat(16'd1000, 1'b0);
        @(negedge clk);
        check("pre_rst_running_sum", 64'(out_sum), 64'd2000);
        check("pre_rst_running_cnt", 64'(out_count), 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_sum", 64'(out_sum), 64'd0);
        check("mid_rst_count", 64'(out_count), 64'd0);
        check("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_exp(24'd5, 8'd1, 1'b0);
        send_beat(16'd5, 1'b1);

        // in_val gaps carrying garbage prod/last must not disturb the packet.
        push_exp(24'd60, 8'd3, 1'b0);
        send_beat(16'd10, 1'b0);
        idle(3);
        send_beat(16'd20, 1'b0);
        idle(2);
        send_beat(16'd30, 1'b1);
        drain();

        // Random packets with input and output stalls.
        rdy_mode = 2;
        for (int pk = 0; pk < 20; pk++) begin
            n         = $urandom_range(1, 8);
            model_sum = 0;
            model_cnt = 0;
            for (int b = 0; b < n; b++) begin
                p = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
                model_sum += 64'(p);
                model_cnt++;
                if (b == n - 1) begin
                    push_exp(SUM_NBITS'(model_sum), CNT_NBITS'(model_cnt),
                             model_sum >= (64'd1 << SUM_NBITS));
                end
                idle($urandom_range(0, 2));
                send_beat(p, b == n - 1);
            end
        end
        drain();
        rdy_mode = 1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
